control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer for an ARM-like datapath. Moore outputs decode from the
// state register and ir; every memory wait is bounded by a 16-cycle timeout.
//
// state    | meaning
// RST      | post-reset idle, all controls low
// F_ADDR   | PC -> MAR
// F_WAIT   | instruction read in flight
// F_IR     | load IR, PC += 4
// DECODE   | condition test and class dispatch
// DP       | data-processing writeback
// LS_ADDR  | base +/- offset -> MAR
// LD_WAIT  | load read in flight
// LD_WB    | MDR -> Rd
// ST_DATA  | Rd -> MDR
// ST_WAIT  | store write in flight
// LINK     | PC -> LR
// BR_TGT   | PC + offset -> PC
module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        cond_ok,
    input  logic        mfa,
    output logic [1:0]  MA,
    output logic [1:0]  MB,
    output logic [2:0]  MC,
    output logic        MD,
    output logic        ME,
    output logic        MH,
    output logic [1:0]  MJ,
    output logic [4:0]  op,
    output logic        rf_ld,
    output logic        ir_ld,
    output logic        mar_ld,
    output logic        mdr_ld,
    output logic        mem_en,
    output logic        mem_rw,
    output logic        mem_err,
    output logic [3:0]  state
);

    localparam logic [4:0] OP_ADD   = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00010;
    localparam logic [4:0] OP_PASSA = 5'b10000;

    typedef enum logic [3:0] {
        S_RST     = 4'd0,
        S_F_ADDR  = 4'd1,
        S_F_WAIT  = 4'd2,
        S_F_IR    = 4'd3,
        S_DECODE  = 4'd4,
        S_DP      = 4'd5,
        S_LS_ADDR = 4'd6,
        S_LD_WAIT = 4'd7,
        S_LD_WB   = 4'd8,
        S_ST_DATA = 4'd9,
        S_ST_WAIT = 4'd10,
        S_LINK    = 4'd11,
        S_BR_TGT  = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       mem_err_q, mem_err_d;
    logic       in_wait;

    logic unused_ir;
    assign unused_ir = ^{ir[31:28], ir[22:21], ir[19:0]};

    assign in_wait = (state_q == S_F_WAIT) || (state_q == S_LD_WAIT) || (state_q == S_ST_WAIT);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            S_RST:     state_d = S_F_ADDR;
            S_F_ADDR:  state_d = S_F_WAIT;
            S_F_WAIT:  if (mfa) state_d = S_F_IR;
            S_F_IR:    state_d = S_DECODE;
            S_DECODE: begin
                if (!cond_ok) begin
                    state_d = S_F_ADDR;
                end else begin
                    case (ir[27:25])
                        3'b000, 3'b001: state_d = S_DP;
                        3'b010:         state_d = S_LS_ADDR;
                        3'b101:         state_d = ir[24] ? S_LINK : S_BR_TGT;
                        default:        state_d = S_F_ADDR;
                    endcase
                end
            end
            S_DP:      state_d = S_F_ADDR;
            S_LS_ADDR: state_d = ir[20] ? S_LD_WAIT : S_ST_DATA;
            S_LD_WAIT: if (mfa) state_d = S_LD_WB;
            S_LD_WB:   state_d = S_F_ADDR;
            S_ST_DATA: state_d = S_ST_WAIT;
            S_ST_WAIT: if (mfa) state_d = S_F_ADDR;
            S_LINK:    state_d = S_BR_TGT;
            S_BR_TGT:  state_d = S_F_ADDR;
            default:   state_d = S_RST;
        endcase

        // An acknowledge on the last allowed cycle still takes the normal exit.
        if (in_wait && !mfa) begin
            if (wait_cnt_q == 4'd15) begin
                mem_err_d = 1'b1;
                state_d   = S_F_ADDR;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end

        if ((state_d != state_q) &&
            ((state_d == S_F_WAIT) || (state_d == S_LD_WAIT) || (state_d == S_ST_WAIT))) begin
            wait_cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_RST;
            wait_cnt_q <= 4'd0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    always_comb begin
        MA     = 2'd0;
        MB     = 2'd0;
        MC     = 3'd0;
        MD     = 1'b0;
        ME     = 1'b0;
        MH     = 1'b0;
        MJ     = 2'd0;
        op     = 5'd0;
        rf_ld  = 1'b0;
        ir_ld  = 1'b0;
        mar_ld = 1'b0;
        mdr_ld = 1'b0;
        mem_en = 1'b0;
        mem_rw = 1'b0;
        case (state_q)
            S_F_ADDR: begin
                MA = 2'd2; MD = 1'b1; op = OP_PASSA; mar_ld = 1'b1;
            end
            S_F_WAIT: begin
                mem_en = 1'b1; mem_rw = 1'b1; mdr_ld = 1'b1;
            end
            S_F_IR: begin
                ir_ld = 1'b1; MA = 2'd2; MB = 2'd3; MD = 1'b1; op = OP_ADD;
                MC = 3'd3; rf_ld = 1'b1;
            end
            S_DP: begin
                MB = {1'b0, ir[25]};
                // TST/TEQ/CMP/CMN (1000..1011) only set flags
                rf_ld = (ir[24:23] != 2'b10);
            end
            S_LS_ADDR: begin
                MB = 2'd2; MD = 1'b1; op = ir[23] ? OP_ADD : OP_SUB; mar_ld = 1'b1;
            end
            S_LD_WAIT: begin
                mem_en = 1'b1; mem_rw = 1'b1; mdr_ld = 1'b1; ME = 1'b1;
            end
            S_LD_WB: begin
                MH = 1'b1; rf_ld = 1'b1;
            end
            S_ST_DATA: begin
                MJ = 2'd2; mdr_ld = 1'b1;
            end
            S_ST_WAIT: begin
                mem_en = 1'b1;
            end
            S_LINK: begin
                MA = 2'd2; MD = 1'b1; op = OP_PASSA; MC = 3'd2; rf_ld = 1'b1;
            end
            S_BR_TGT: begin
                MA = 2'd2; MB = 2'd1; MD = 1'b1; op = OP_ADD; MC = 3'd3; rf_ld = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction scenarios plus random traffic,
// each cycle compared against a cycle-budget model of the sequencing rules.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset, cond_ok, mfa;
    logic [31:0] ir;
    logic [1:0]  MA, MB, MJ;
    logic [2:0]  MC;
    logic        MD, ME, MH;
    logic [4:0]  op;
    logic        rf_ld, ir_ld, mar_ld, mdr_ld, mem_en, mem_rw, mem_err;
    logic [3:0]  state;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset(reset), .ir(ir), .cond_ok(cond_ok), .mfa(mfa),
        .MA(MA), .MB(MB), .MC(MC), .MD(MD), .ME(ME), .MH(MH), .MJ(MJ), .op(op),
        .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld),
        .mem_en(mem_en), .mem_rw(mem_rw), .mem_err(mem_err), .state(state)
    );

    typedef struct packed {
        logic [1:0] ma;
        logic [1:0] mb;
        logic [2:0] mc;
        logic       md, me, mh;
        logic [1:0] mj;
        logic [4:0] op;
        logic       rf, irl, marl, mdrl, en, rw;
    } ctl_t;

    ctl_t dut_ctl;
    assign dut_ctl = {MA, MB, MC, MD, ME, MH, MJ, op, rf_ld, ir_ld, mar_ld, mdr_ld, mem_en, mem_rw};

    int          errors = 0;
    int          checks = 0;
    int          m_state = 0;
    int          m_budget = 16;
    logic        m_err = 1'b0;
    logic [27:0] got, want;

    function automatic ctl_t exp_ctl(input int s, input logic [31:0] i);
        ctl_t c;
        c = '0;
        case (s)
            1:  begin c.ma = 2'd2; c.md = 1'b1; c.op = 5'b10000; c.marl = 1'b1; end
            2:  begin c.en = 1'b1; c.rw = 1'b1; c.mdrl = 1'b1; end
            3:  begin c.irl = 1'b1; c.ma = 2'd2; c.mb = 2'd3; c.md = 1'b1; c.op = 5'b00100;
                      c.mc = 3'd3; c.rf = 1'b1; end
            5:  begin c.mb = i[25] ? 2'd1 : 2'd0;
                      c.rf = (i[24:21] < 4'd8) || (i[24:21] > 4'd11); end
            6:  begin c.mb = 2'd2; c.md = 1'b1; c.op = i[23] ? 5'b00100 : 5'b00010;
                      c.marl = 1'b1; end
            7:  begin c.en = 1'b1; c.rw = 1'b1; c.mdrl = 1'b1; c.me = 1'b1; end
            8:  begin c.mh = 1'b1; c.rf = 1'b1; end
            9:  begin c.mj = 2'd2; c.mdrl = 1'b1; end
            10: begin c.en = 1'b1; end
            11: begin c.ma = 2'd2; c.md = 1'b1; c.op = 5'b10000; c.mc = 3'd2; c.rf = 1'b1; end
            12: begin c.ma = 2'd2; c.mb = 2'd1; c.md = 1'b1; c.op = 5'b00100; c.mc = 3'd3;
                      c.rf = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    // Reference: each wait state grants a budget of 16 cycles; each unacknowledged cycle spends one.
    task automatic model_step(input logic r, input logic c, input logic m);
        int nxt;
        bit waiting;
        if (r) begin
            m_state = 0;
            m_err   = 1'b0;
            m_budget = 16;
        end else begin
            waiting = (m_state == 2) || (m_state == 7) || (m_state == 10);
            case (m_state)
                0:  nxt = 1;
                1:  nxt = 2;
                2:  nxt = 3;
                3:  nxt = 4;
                4: begin
                    if (!c) nxt = 1;
                    else if (ir[27:25] <= 3'd1) nxt = 5;
                    else if (ir[27:25] == 3'd2) nxt = 6;
                    else if (ir[27:25] == 3'd5) nxt = ir[24] ? 11 : 12;
                    else nxt = 1;
                end
                5:  nxt = 1;
                6:  nxt = ir[20] ? 7 : 9;
                7:  nxt = 8;
                8:  nxt = 1;
                9:  nxt = 10;
                10: nxt = 1;
                11: nxt = 12;
                default: nxt = 1;
            endcase
            if (waiting && !m) begin
                m_budget--;
                if (m_budget == 0) begin
                    m_err = 1'b1;
                    nxt = 1;
                end else begin
                    nxt = m_state;
                end
            end
            if (nxt != m_state && (nxt == 2 || nxt == 7 || nxt == 10)) m_budget = 16;
            m_state = nxt;
        end
    endtask

    task automatic tick(input logic r, input logic c, input logic m);
        reset = r; cond_ok = c; mfa = m;
        model_step(r, c, m);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        ir = 32'h0; cond_ok = 1'b0; mfa = 1'b0;
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        checks++;
        if ({state, mem_err, dut_ctl} !== 28'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", {state, mem_err, dut_ctl});
        end
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 4'd1 || dut_ctl !== exp_ctl(1, ir)) begin
            errors++;
            $display("FAIL reset_first_cycle: got state %0d ctl %h want state 1 ctl %h",
                     state, dut_ctl, exp_ctl(1, ir));
        end
    endtask

    task automatic test_add;
        int seq [6] = '{1, 2, 3, 4, 5, 1};
        ir = 32'hE0812003;
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
            checks++;
            if (got !== want || state !== 4'(seq[i])) begin
                errors++;
                $display("FAIL add_seq cycle %0d: got %h want %h (state want %0d)", i, got, want, seq[i]);
            end
            if (i == 4) begin
                checks++;
                if ({rf_ld, MC, MD, MB} !== {1'b1, 3'd0, 1'b0, 2'd0}) begin
                    errors++;
                    $display("FAIL add_dp_ctl: got rf_ld=%b MC=%0d MD=%b MB=%0d want 1 0 0 0",
                             rf_ld, MC, MD, MB);
                end
            end
        end
    endtask

    task automatic test_cmp;
        ir = 32'hE1510002;
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL cmp_seq cycle %0d: got %h want %h", i, got, want);
            end
        end
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL cmp_after_dp: got state %0d want 1", state);
        end
    endtask

    task automatic test_ldr;
        int low = 0, ld_cycles = 0;
        bit saw_wb = 0;
        logic m;
        ir = 32'hE5912004;
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            m = !(m_state == 7 && low < 3);
            if (!m) low++;
            tick(1'b0, 1'b1, m);
            got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL ldr_seq cycle %0d: got %h want %h", i, got, want);
            end
            if (state == 4'd6) begin
                checks++;
                if (op !== 5'b00100) begin
                    errors++;
                    $display("FAIL ldr_addr_op: got %b want 00100", op);
                end
            end
            if (state == 4'd7) ld_cycles++;
            if (state == 4'd8) begin
                saw_wb = 1;
                checks++;
                if (MH !== 1'b1 || rf_ld !== 1'b1) begin
                    errors++;
                    $display("FAIL ldr_wb: got MH=%b rf_ld=%b want 1 1", MH, rf_ld);
                end
            end
        end
        checks++;
        if (ld_cycles != 4 || !saw_wb) begin
            errors++;
            $display("FAIL ldr_wait_len: got %0d cycles wb=%0d want 4 cycles wb=1", ld_cycles, saw_wb);
        end
    endtask

    task automatic test_bl;
        bit saw_link = 0, saw_tgt = 0;
        ir = 32'hEB000010;
        tick(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bl_seq cycle %0d: got %h want %h", i, got, want);
            end
            if (state == 4'd11) saw_link = 1;
            if (state == 4'd12) begin
                saw_tgt = 1;
                checks++;
                if ({MC, MB, op} !== {3'd3, 2'd1, 5'b00100}) begin
                    errors++;
                    $display("FAIL bl_target: got MC=%0d MB=%0d op=%b want 3 1 00100", MC, MB, op);
                end
            end
        end
        checks++;
        if (!saw_link || !saw_tgt) begin
            errors++;
            $display("FAIL bl_path: got link=%0d target=%0d want 1 1", saw_link, saw_tgt);
        end
    endtask

    task automatic test_timeout;
        int fw_cycles = 0;
        ir = 32'hE0812003;
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        if (state == 4'd2) fw_cycles++;
        for (int k = 1; k <= 16; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (state == 4'd2) fw_cycles++;
            got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL timeout_wait k=%0d: got %h want %h", k, got, want);
            end
        end
        checks++;
        if (fw_cycles != 16 || state !== 4'd1 || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_exit: got %0d cycles state %0d err %b want 16 1 1",
                     fw_cycles, state, mem_err);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b1, 1'b1);
            got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
            checks++;
            if (got !== want || mem_err !== 1'b1) begin
                errors++;
                $display("FAIL timeout_sticky cycle %0d: got %h want %h", i, got, want);
            end
        end
        tick(1'b1, 1'b1, 1'b1);
        checks++;
        if (mem_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got err %b want 0", mem_err);
        end
    endtask

    task automatic test_timeout_edge;
        ir = 32'hE0812003;
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 15; k++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        checks++;
        if (state !== 4'd3 || mem_err !== 1'b0 || m_state != 3) begin
            errors++;
            $display("FAIL timeout_edge: got state %0d err %b want 3 0", state, mem_err);
        end
    endtask

    task automatic test_reset_mid_wait;
        ir = 32'hE5812004;
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1);
        for (int k = 1; k <= 16; k++) tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && m_state != 10; i++) tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
        checks++;
        if (got !== want || state !== 4'd10 || mem_en !== 1'b1 || mem_err !== 1'b1) begin
            errors++;
            $display("FAIL store_wait: got %h want %h (state 10 err 1)", got, want);
        end
        tick(1'b1, 1'b1, 1'b0);
        checks++;
        if (state !== 4'd0 || mem_en !== 1'b0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_wait: got state %0d en %b err %b want 0 0 0", state, mem_en, mem_err);
        end
        tick(1'b0, 1'b1, 1'b0);
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL reset_in_wait_resume: got state %0d want 1", state);
        end
    endtask

    task automatic test_random;
        int   low_run = 0;
        logic r, c, m;
        logic [2:0] cls;
        tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 63) == 0);
            c = ($urandom_range(0, 3) != 0);
            if (low_run > 0) begin
                m = 1'b0;
                low_run--;
            end else begin
                if ($urandom_range(0, 39) == 0) low_run = $urandom_range(12, 24);
                m = ($urandom_range(0, 3) != 0);
            end
            ir = $urandom;
            case ($urandom_range(0, 4))
                0: cls = 3'b000;
                1: cls = 3'b001;
                2: cls = 3'b010;
                3: cls = 3'b101;
                default: cls = ir[27:25];
            endcase
            ir[27:25] = cls;
            tick(r, c, m);
            got = {state, mem_err, dut_ctl}; want = {4'(m_state), m_err, exp_ctl(m_state, ir)};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL random cycle %0d: got %h want %h ir %h", i, got, want, ir);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_ldr();
        test_bl();
        test_timeout();
        test_timeout_edge();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
